demux_scan_ctrl: RTL

Upstream sequencer for the 1-to-16 demultiplexer stage. On a start pulse it walks every enabled channel in a 16-bit mask, lowest index first. For each enabled channel it drives the 4-bit select and asserts the data strobe for a programmable dwell time. Its `sel` and `dout` outputs connect directly to the demux select and data inputs.

---
 rtl/demux_pkg.sv | 17 +
 rtl/demux_next_chan.sv | 52 +++++
 rtl/demux_scan_ctrl.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/demux_pkg.sv
// Shared types and constants for the demux scan sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package demux_pkg;

    localparam int NUM_CH      = 16;
    localparam int SEL_W       = 4;
    localparam int DWELL_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/demux_next_chan.sv
// Finds the next enabled channel in a 16-bit mask relative to a current index.
// Latency: purely combinational.
// Backpressure: none; result is valid whenever inputs are stable.
module demux_next_chan
    import demux_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    input  logic              first,
    input  logic              wrap_en,
    output logic [SEL_W-1:0]  nxt,
    output logic              found
);

    logic             hit_above;
    logic             hit_low;
    logic [SEL_W-1:0] idx_above;
    logic [SEL_W-1:0] idx_low;

    // Scan from the top down so the last match written is the lowest index.
    // 'first' makes cur itself eligible, which gives "from below 0" in LOAD.
    always_comb begin
        hit_above = 1'b0;
        hit_low   = 1'b0;
        idx_above = '0;
        idx_low   = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                hit_low = 1'b1;
                idx_low = i[SEL_W-1:0];
                if ((i > int'(cur)) || (first && (i == int'(cur)))) begin
                    hit_above = 1'b1;
                    idx_above = i[SEL_W-1:0];
                end
            end
        end
    end

    // Prefer a channel above cur; fall back to the lowest one only when wrapping.
    always_comb begin
        nxt   = '0;
        found = 1'b0;
        if (hit_above) begin
            nxt   = idx_above;
            found = 1'b1;
        end else if (wrap_en && hit_low) begin
            nxt   = idx_low;
            found = 1'b1;
        end
    end

endmodule

// File: rtl/demux_scan_ctrl.sv
// Walks enabled channels of a 16-bit mask, strobing dout for dwell cycles each (DEMUX_SCAN_LOOP_EN: continuous mode with stop).
// Latency: start -> LOAD next cycle -> first strobe the cycle after; done one cycle after the last strobe.
// Backpressure: none; start is ignored (not queued) while busy or in DONE.
module demux_scan_ctrl
    import demux_pkg::*;
#(
    parameter int DWELL_W = DWELL_W_DEF
)
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               stop,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [NUM_CH-1:0]  chan_mask,
    output logic [SEL_W-1:0]   sel,
    output logic               dout,
    output logic               busy,
    output logic               done
);

    state_t             state;
    state_t             state_n;
    logic [NUM_CH-1:0]  mask_q;
    logic [DWELL_W-1:0] dwell_q;
    logic [DWELL_W-1:0] cnt;
    logic [DWELL_W-1:0] cnt_n;
    logic [DWELL_W-1:0] reload;
    logic [SEL_W-1:0]   sel_n;
    logic               dout_n;
    logic               busy_n;
    logic               done_n;

    logic [SEL_W-1:0]   f_cur;
    logic               f_first;
    logic [SEL_W-1:0]   f_nxt;
    logic               f_found;
    logic               wrap_en;
    logic               stop_now;

    // A zero dwell is treated as one cycle, so the counter reload is dwell_eff-1.
    assign reload = (dwell_q == '0) ? '0 : dwell_q - {{(DWELL_W-1){1'b0}}, 1'b1};

    // In LOAD search from index 0 inclusive; in DWELL search strictly above sel.
    assign f_first = (state == LOAD);
    assign f_cur   = (state == LOAD) ? '0 : sel;

    demux_next_chan u_next_chan (
        .mask    (mask_q),
        .cur     (f_cur),
        .first   (f_first),
        .wrap_en (wrap_en),
        .nxt     (f_nxt),
        .found   (f_found)
    );

`ifdef DEMUX_SCAN_LOOP_EN
    logic stop_q;

    // Remember a stop request until the scan ends; a fresh start clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stop_q <= 1'b0;
        end else if (state == IDLE && start) begin
            stop_q <= 1'b0;
        end else if ((state == LOAD || state == DWELL) && stop) begin
            stop_q <= 1'b1;
        end
    end

    // Live stop counts too, so a stop on the last dwell cycle takes effect at once.
    assign stop_now = stop_q | stop;
    assign wrap_en  = (state == DWELL);
`else
    logic unused_stop;
    assign unused_stop = stop;
    assign stop_now    = 1'b0;
    assign wrap_en     = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state decode.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (start) state_n = LOAD;
            LOAD:    state_n = f_found ? DWELL : DONE;
            DWELL: begin
                if (cnt != '0) begin
                    state_n = DWELL;
                end else if (!stop_now && f_found) begin
                    state_n = DWELL;
                end else begin
                    state_n = DONE;
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Next values of the registered outputs and dwell counter, aligned with state_n.
    always_comb begin
        sel_n  = sel;
        dout_n = 1'b0;
        busy_n = 1'b0;
        done_n = 1'b0;
        cnt_n  = cnt;
        case (state)
            IDLE: begin
                if (start) busy_n = 1'b1;
            end
            LOAD: begin
                if (f_found) begin
                    sel_n  = f_nxt;
                    dout_n = 1'b1;
                    busy_n = 1'b1;
                    cnt_n  = reload;
                end else begin
                    done_n = 1'b1;
                end
            end
            DWELL: begin
                if (cnt != '0) begin
                    cnt_n  = cnt - {{(DWELL_W-1){1'b0}}, 1'b1};
                    dout_n = 1'b1;
                    busy_n = 1'b1;
                end else if (!stop_now && f_found) begin
                    sel_n  = f_nxt;
                    dout_n = 1'b1;
                    busy_n = 1'b1;
                    cnt_n  = reload;
                    // Moving to an index not above the current one means we wrapped.
                    done_n = (f_nxt <= sel);
                end else begin
                    done_n = 1'b1;
                end
            end
            default: begin
                done_n = 1'b0;
            end
        endcase
    end

    // Output, counter and configuration registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel     <= '0;
            dout    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            cnt     <= '0;
            mask_q  <= '0;
            dwell_q <= '0;
        end else begin
            sel  <= sel_n;
            dout <= dout_n;
            busy <= busy_n;
            done <= done_n;
            cnt  <= cnt_n;
            if (state == IDLE && start) begin
                mask_q  <= chan_mask;
                dwell_q <= dwell;
            end
        end
    end

endmodule
